multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, the unified instruction/data memory port and the immediate-extension unit.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti) and beq.
- Waits on a memory-ready handshake and flags illegal instructions.

Parameters:
- MEM_WAIT_MAX, 15, cycles to wait for mem_ready before setting mem_timeout; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- mem_req  out  1  memory access request; hold until mem_ready
- pc_write  out  1  PC register load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  store strobe
- ir_write  out  1  instruction register and oldPC load enable
- reg_write  out  1  register file write enable
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1 register
- alu_src_b  out  2  00 rs2 register, 01 imm_ext, 10 constant 4
- imm_src  out  2  00 I-type, 01 S-type, 10 B-type
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  sticky illegal-opcode/funct flag
- mem_timeout  out  1  sticky memory timeout flag
- state  out  4  current state encoding, for debug

Behaviour:
- Outputs are Moore decodes of the state, plus funct decode in EXEC_R/EXEC_I. Every output not listed for a state is 0.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BEQ=9, TRAP=10.
- Reset:
  - state=FETCH, illegal=0, mem_timeout=0, wait counter=0.
  - All strobes are 0 in the reset cycle.
  - Reset asserted in any state, including mid-memory-wait, aborts the access; FETCH is entered on the next edge.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_control=add, result_src=10.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; that same edge moves to DECODE.
  - While mem_ready=0: stay in FETCH, no state change.
- DECODE:
  - alu_src_a=01, alu_src_b=01, imm_src=10, alu_control=add (precomputes the branch target into ALUOut).
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BEQ
    - anything else -> TRAP
- MEMADR:
  - alu_src_a=10, alu_src_b=01, alu_control=add.
  - imm_src=00 for lw, 01 for sw.
  - Next state is MEMRD for lw, MEMWR for sw.
- MEMRD:
  - mem_req=1, adr_src=1.
  - Goes to MEMWB when mem_ready=1.
- MEMWB:
  - result_src=01, reg_write=1.
  - Next state FETCH.
- MEMWR:
  - mem_req=1, adr_src=1.
  - mem_write=1 only in the cycle mem_ready=1; then FETCH.
- EXEC_R:
  - alu_src_a=10, alu_src_b=00.
  - funct3 decode: 000 -> sub if funct7b5 else add; 010 -> slt; 110 -> or; 111 -> and.
  - Next state ALUWB.
- EXEC_I:
  - As EXEC_R but alu_src_b=01, imm_src=00; funct7b5 is ignored (000 is always add).
  - Next state ALUWB.
- ALUWB:
  - result_src=00, reg_write=1.
  - Next state FETCH.
- BEQ:
  - alu_src_a=10, alu_src_b=00, alu_control=sub, result_src=00.
  - pc_write=zero.
  - funct3 other than 000 -> TRAP with no pc_write; otherwise next state FETCH.
- Unsupported funct3 in EXEC_R/EXEC_I: alu_control=add, next state TRAP, no reg_write.
- TRAP:
  - illegal=1 (sticky); all strobes 0.
  - Stays in TRAP until rst.
- Memory wait counter:
  - Counts consecutive mem_ready=0 cycles in FETCH/MEMRD/MEMWR.
  - Clears on mem_ready=1 and on any state change.
  - On reaching MEM_WAIT_MAX: mem_timeout=1 (sticky), state goes to TRAP, illegal is left unchanged.
- mem_ready outside a memory state is ignored.
- Latency with zero wait states:
  - lw 5 cycles
  - sw 4
  - R/I-type 4
  - beq 3

Test Plan:
- Reset mid-MEMRD wait (mem_ready held 0) -> next cycle state=0, all strobes 0, flags 0; a fetch then proceeds normally.
- lw 0x00412083, mem_ready always 1 -> state sequence 0,1,2,3,4,0; imm_src=00 in MEMADR; reg_write=1 with result_src=01 only in cycle 5.
- sw 0x00112223, mem_ready delayed 3 cycles in MEMWR -> mem_req high 4 cycles; mem_write=1 in the final cycle only; total 7 cycles.
- R-type sub 0x40208033 -> alu_control=001 in EXEC_R; and 0x0020F033 -> 010; addi with instr[30]=1 -> alu_control=000.
- beq: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
- Two trap cases:
  - opcode 0110111 -> TRAP with illegal=1, held for 20 cycles until rst.
  - mem_ready stuck 0 in FETCH with MEM_WAIT_MAX=15 -> mem_timeout=1 after 15 cycles, state=10.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle RV32I controller and its datapath.
// The controller uses the master modport; the datapath (or a bench) uses slave.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       illegal;
  logic       mem_timeout;
  logic [3:0] state;

  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output mem_req, pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control,
           illegal, mem_timeout, state
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  mem_req, pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control,
           illegal, mem_timeout, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: fetch/decode/execute/memory/writeback
// sequencing over a shared ALU and unified memory port, with memory-wait timeout.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBeq    = 4'd9,
    StTrap   = 4'd10
  } state_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam int unsigned CntW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'((MEM_WAIT_MAX == 0) ? 0 : MEM_WAIT_MAX - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            illegal_q, illegal_d;
  logic            timeout_q, timeout_d;

  logic            waiting;
  logic            funct_ok;
  logic [2:0]      exec_alu;

  // ALU operation for EXEC_R/EXEC_I; funct7b5 only selects sub for register ops.
  always_comb begin
    funct_ok = 1'b1;
    exec_alu = AluAdd;
    case (bus.funct3)
      3'b000:  exec_alu = (state_q == StExecR && bus.funct7b5) ? AluSub : AluAdd;
      3'b010:  exec_alu = AluSlt;
      3'b110:  exec_alu = AluOr;
      3'b111:  exec_alu = AluAnd;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    waiting   = (state_q inside {StFetch, StMemRd, StMemWr}) && !bus.mem_ready;

    unique case (state_q)
      StFetch:  if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        unique case (bus.opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBeq:           state_d = StBeq;
          default: begin
            state_d   = StTrap;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAdr: state_d = (bus.opcode == OpStore) ? StMemWr : StMemRd;
      StMemRd:  if (bus.mem_ready) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (bus.mem_ready) state_d = StFetch;
      StExecR, StExecI: begin
        state_d = funct_ok ? StAluWb : StTrap;
        if (!funct_ok) illegal_d = 1'b1;
      end
      StAluWb:  state_d = StFetch;
      StBeq: begin
        state_d = (bus.funct3 == 3'b000) ? StFetch : StTrap;
        if (bus.funct3 != 3'b000) illegal_d = 1'b1;
      end
      StTrap:   state_d = StTrap;
      default:  state_d = StTrap;
    endcase

    // Timeout overrides the normal stay-in-state while waiting on memory.
    if (waiting && MEM_WAIT_MAX != 0 && cnt_q == WaitLast) begin
      state_d   = StTrap;
      timeout_d = 1'b1;
    end

    cnt_d = (waiting && state_d == state_q) ? cnt_q + CntW'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Moore decode of the state; handshake strobes follow mem_ready/zero combinationally.
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.pc_write    = 1'b0;
    bus.adr_src     = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.result_src  = 2'b00;
    bus.alu_src_a   = 2'b00;
    bus.alu_src_b   = 2'b00;
    bus.imm_src     = 2'b00;
    bus.alu_control = AluAdd;
    bus.illegal     = illegal_q;
    bus.mem_timeout = timeout_q;
    bus.state       = state_q;
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          bus.mem_req    = 1'b1;
          bus.alu_src_b  = 2'b10;
          bus.result_src = 2'b10;
          bus.ir_write   = bus.mem_ready;
          bus.pc_write   = bus.mem_ready;
        end
        StDecode: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b01;
          bus.imm_src   = 2'b10;
        end
        StMemAdr: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b01;
          bus.imm_src   = (bus.opcode == OpStore) ? 2'b01 : 2'b00;
        end
        StMemRd: begin
          bus.mem_req = 1'b1;
          bus.adr_src = 1'b1;
        end
        StMemWb: begin
          bus.result_src = 2'b01;
          bus.reg_write  = 1'b1;
        end
        StMemWr: begin
          bus.mem_req   = 1'b1;
          bus.adr_src   = 1'b1;
          bus.mem_write = bus.mem_ready;
        end
        StExecR: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_control = exec_alu;
        end
        StExecI: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_src_b   = 2'b01;
          bus.alu_control = exec_alu;
        end
        StAluWb: bus.reg_write = 1'b1;
        StBeq: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_control = AluSub;
          bus.pc_write    = bus.zero && (bus.funct3 == 3'b000);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: instruction scripts push expected per-cycle
// outputs into a queue; a negedge monitor pops and compares against the DUT.
module tb_multicycle_ctrl;

  localparam int unsigned WaitMax = 15;

  typedef struct packed {
    logic       mem_req;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
  } outs_t;

  typedef struct {
    logic [3:0] st;
    bit         chk_st;
    outs_t      o;
    logic       ill;
    logic       tmo;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  multicycle_ctrl_if bus ();

  multicycle_ctrl #(
    .MEM_WAIT_MAX (WaitMax)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  ill_m  = 1'b0;
  logic  tmo_m  = 1'b0;
  string tag    = "init";

  // Monitor: compare whatever the driver expected for this cycle.
  initial begin
    exp_t  e;
    outs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.mem_req, bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
             bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
             bus.alu_control};
        checks++;
        if ((e.chk_st && bus.state !== e.st) || a !== e.o || bus.illegal !== e.ill ||
            bus.mem_timeout !== e.tmo) begin
          errors++;
          $display("FAIL %s @%0t: got state=%0d outs=%h ill=%b tmo=%b, expected state=%0d%s outs=%h ill=%b tmo=%b",
                   e.tag, $time, bus.state, a, bus.illegal, bus.mem_timeout, e.st,
                   e.chk_st ? "" : "(unchecked)", e.o, e.ill, e.tmo);
        end
      end
    end
  end

  function automatic logic rnd_bit();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic cyc(input logic rdy, input logic [3:0] st, input outs_t o);
    exp_t e;
    bus.mem_ready = rdy;
    e.st = st; e.chk_st = 1'b1; e.o = o; e.ill = ill_m; e.tmo = tmo_m; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    e.st = 4'd0; e.chk_st = 1'b0; e.o = '0; e.ill = ill_m; e.tmo = tmo_m; e.tag = "reset";
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    ill_m = 1'b0;
    tmo_m = 1'b0;
    e.chk_st = 1'b1; e.ill = 1'b0; e.tmo = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic trap_phase(input int len);
    for (int i = 0; i < len; i++) cyc(rnd_bit(), 4'd10, outs_t'('0));
    do_reset();
  endtask

  // Memory handshake phase; ended=1 when the instruction stops early (abort or timeout).
  task automatic mem_phase(input logic [3:0] st, input outs_t base, input int waits,
                           input int abort, input int tlen, output bit ended);
    outs_t o;
    ended = 1'b0;
    for (int i = 0; i < waits; i++) begin
      if (abort >= 0 && i == abort) begin
        do_reset();
        ended = 1'b1;
        return;
      end
      cyc(1'b0, st, base);
      if (WaitMax != 0 && i + 1 == int'(WaitMax)) begin
        tmo_m = 1'b1;
        trap_phase(tlen);
        ended = 1'b1;
        return;
      end
    end
    o = base;
    if (st == 4'd0) begin
      o.pc_write = 1'b1;
      o.ir_write = 1'b1;
    end
    if (st == 4'd5) o.mem_write = 1'b1;
    cyc(1'b1, st, o);
  endtask

  // ALU operation for R/I-type; ok=0 for unsupported funct3.
  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub, output bit ok);
    ok = 1'b1;
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: begin ok = 1'b0; return 3'b000; end
    endcase
  endfunction

  task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input logic z,
                           input int abort, input int tlen, input string name);
    outs_t      o;
    bit         ended, ok, is_sw, is_r;
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    tag = name;
    bus.opcode = op; bus.funct3 = f3; bus.funct7b5 = ins[30]; bus.zero = z;

    o = '0; o.mem_req = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
    mem_phase(4'd0, o, wf, -1, tlen, ended);
    if (ended) return;
    o = '0; o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; o.imm_src = 2'b10;
    cyc(rnd_bit(), 4'd1, o);

    case (op)
      7'b0000011, 7'b0100011: begin
        is_sw = (op == 7'b0100011);
        o = '0; o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.imm_src = is_sw ? 2'b01 : 2'b00;
        cyc(rnd_bit(), 4'd2, o);
        o = '0; o.mem_req = 1'b1; o.adr_src = 1'b1;
        mem_phase(is_sw ? 4'd5 : 4'd3, o, wm, abort, tlen, ended);
        if (ended) return;
        if (!is_sw) begin
          o = '0; o.result_src = 2'b01; o.reg_write = 1'b1;
          cyc(rnd_bit(), 4'd4, o);
        end
      end
      7'b0110011, 7'b0010011: begin
        is_r = (op == 7'b0110011);
        o = '0; o.alu_src_a = 2'b10; o.alu_src_b = is_r ? 2'b00 : 2'b01;
        o.alu_control = alu_of(f3, is_r && ins[30], ok);
        cyc(rnd_bit(), is_r ? 4'd6 : 4'd7, o);
        if (!ok) begin
          ill_m = 1'b1;
          trap_phase(tlen);
          return;
        end
        o = '0; o.reg_write = 1'b1;
        cyc(rnd_bit(), 4'd8, o);
      end
      7'b1100011: begin
        o = '0; o.alu_src_a = 2'b10; o.alu_control = 3'b001;
        o.pc_write = z && (f3 == 3'b000);
        cyc(rnd_bit(), 4'd9, o);
        if (f3 != 3'b000) begin
          ill_m = 1'b1;
          trap_phase(tlen);
        end
      end
      default: begin
        ill_m = 1'b1;
        trap_phase(tlen);
      end
    endcase
  endtask

  initial begin
    logic [31:0] ins;
    logic [2:0]  legal_f3 [4];
    int          wf, wm;
    legal_f3[0] = 3'b000; legal_f3[1] = 3'b010; legal_f3[2] = 3'b110; legal_f3[3] = 3'b111;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_instr(32'h00412083, 0, 10, 1'b0, 2, 3, "lw_abort");
    run_instr(32'h00412083, 0, 0, 1'b0, -1, 3, "lw");
    run_instr(32'h00112223, 0, 3, 1'b0, -1, 3, "sw_wait3");
    run_instr(32'h40208033, 0, 0, 1'b0, -1, 3, "sub");
    run_instr(32'h0020F033, 0, 0, 1'b0, -1, 3, "and");
    run_instr(32'h40008093, 0, 0, 1'b0, -1, 3, "addi_b30");
    run_instr(32'h00208063, 0, 0, 1'b1, -1, 3, "beq_taken");
    run_instr(32'h00208063, 0, 0, 1'b0, -1, 3, "beq_not");
    run_instr(32'h12345037, 0, 0, 1'b0, -1, 20, "lui_trap");
    run_instr(32'h00412083, 20, 0, 1'b0, -1, 3, "fetch_tmo");
    run_instr(32'h00412083, 0, 16, 1'b0, -1, 3, "memrd_tmo");

    for (int n = 0; n < 150; n++) begin
      ins = $urandom();
      case ($urandom_range(6, 0))
        0:       ins[6:0] = 7'b0000011;
        1:       ins[6:0] = 7'b0100011;
        2:       ins[6:0] = 7'b0110011;
        3:       ins[6:0] = 7'b0010011;
        4:       ins[6:0] = 7'b1100011;
        5:       ins[6:0] = 7'($urandom());
        default: ins[6:0] = 7'b0110011;
      endcase
      if ($urandom_range(3, 0) != 0) ins[14:12] = legal_f3[$urandom_range(3, 0)];
      if (ins[6:0] == 7'b1100011 && $urandom_range(1, 0) == 1) ins[14:12] = 3'b000;
      wf = ($urandom_range(19, 0) == 0) ? 15 : int'($urandom_range(3, 0));
      wm = ($urandom_range(19, 0) == 0) ? 15 : int'($urandom_range(3, 0));
      run_instr(ins, wf, wm, rnd_bit(), -1, int'($urandom_range(5, 1)), "random");
    end

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
